// File: rtl/gradient_tx_packer.sv
// gradient_tx_packer
// Packs a stream of float gradients into wide lines of DATALINE_SIZE lanes.
// A line closes when its last lane is written or when a batch ends.
// Each closed line carries a per-byte TKEEP mask, and TLAST marks the final line of a batch.
// There are two line stages. The assembly line gathers lanes and can hold one
// closed line while it waits. The output register presents lines downstream.
// Optional feature: define GRADIENT_TX_ZERO_PAD_EN to drive unused lanes of a
// partial line to zero. Without it, those lanes carry stale data.
module gradient_tx_packer #(
  parameter int FLOAT_SIZE    = 32,
  parameter int DATALINE_SIZE = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [31:0]                         num_gradients,
  input  logic [FLOAT_SIZE-1:0]               batch_gradient_TDATA,
  input  logic                                batch_gradient_TVALID,
  output logic                                batch_gradient_TREADY,
  output logic [FLOAT_SIZE*DATALINE_SIZE-1:0] m_axis_tx_data_TDATA,
  output logic [FLOAT_SIZE*DATALINE_SIZE/8-1:0] m_axis_tx_data_TKEEP,
  output logic                                m_axis_tx_data_TVALID,
  output logic                                m_axis_tx_data_TLAST,
  input  logic                                m_axis_tx_data_TREADY
);

  localparam int LINE_W     = FLOAT_SIZE * DATALINE_SIZE;
  localparam int KEEP_W     = LINE_W / 8;
  localparam int LANE_BYTES = FLOAT_SIZE / 8;
  localparam int LANE_W     = $clog2(DATALINE_SIZE);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(DATALINE_SIZE - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]        state;
  logic [31:0]       remaining;
  logic [LANE_W-1:0] lane_idx;
  logic              ready_en;

  logic [LINE_W-1:0] asm_data;
  logic [KEEP_W-1:0] asm_keep;
  logic              asm_last;
  logic              asm_closed;

  logic [LINE_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic              out_last;
  logic              out_valid;

  logic              out_free;
  logic              grad_ready;
  logic              accept;
  logic [31:0]       batch_len;
  logic              is_last;
  logic              close_now;
  logic              move_pending;
  logic              direct;
  logic              park;
  logic [LINE_W-1:0] line_data;
  logic [KEEP_W-1:0] line_keep;

  // Handshake decisions and routing of a closing line
  always_comb begin
    out_free     = !out_valid || m_axis_tx_data_TREADY;
    grad_ready   = ready_en && (!asm_closed || out_free);
    accept       = batch_gradient_TVALID && grad_ready;
    batch_len    = (num_gradients == 32'd0) ? 32'd1 : num_gradients;
    is_last      = (state == IDLE) ? (batch_len == 32'd1) : (remaining == 32'd1);
    close_now    = accept && ((lane_idx == LAST_LANE) || is_last);
    move_pending = asm_closed && out_free;
    direct       = close_now && out_free && !asm_closed;
    park         = close_now && !direct;
  end

  // Assembly line with the incoming gradient merged into its lane
  always_comb begin
`ifdef GRADIENT_TX_ZERO_PAD_EN
    line_data = (lane_idx == '0) ? '0 : asm_data;
`else
    line_data = asm_data;
`endif
    line_data[int'(lane_idx) * FLOAT_SIZE +: FLOAT_SIZE] = batch_gradient_TDATA;
    line_keep = '0;
    for (int k = 0; k < DATALINE_SIZE; k++) begin
      line_keep[k * LANE_BYTES +: LANE_BYTES] =
        (k <= int'(lane_idx)) ? {LANE_BYTES{1'b1}} : {LANE_BYTES{1'b0}};
    end
  end

  // Batch tracking: open/close state, remaining count and lane position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      lane_idx  <= '0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        lane_idx <= close_now ? '0 : lane_idx + 1'b1;
        if (is_last) begin
          state     <= IDLE;
          remaining <= '0;
        end else begin
          state     <= ACCUM;
          remaining <= (state == IDLE) ? batch_len - 32'd1 : remaining - 32'd1;
        end
      end
    end
  end

  // Assembly storage. A closed line parks here if the output register is busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_data   <= '0;
      asm_keep   <= '0;
      asm_last   <= 1'b0;
      asm_closed <= 1'b0;
    end else begin
      if (accept) asm_data <= line_data;
      if (park) begin
        asm_closed <= 1'b1;
        asm_keep   <= line_keep;
        asm_last   <= is_last;
      end else if (move_pending) begin
        asm_closed <= 1'b0;
      end
    end
  end

  // One-entry output register. It takes a parked line first, otherwise a directly closed line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (move_pending) begin
      out_data  <= asm_data;
      out_keep  <= asm_keep;
      out_last  <= asm_last;
      out_valid <= 1'b1;
    end else if (direct) begin
      out_data  <= line_data;
      out_keep  <= line_keep;
      out_last  <= is_last;
      out_valid <= 1'b1;
    end else if (m_axis_tx_data_TREADY) begin
      out_valid <= 1'b0;
    end
  end

  assign batch_gradient_TREADY = grad_ready;
  assign m_axis_tx_data_TDATA  = out_data;
  assign m_axis_tx_data_TKEEP  = out_keep;
  assign m_axis_tx_data_TLAST  = out_last;
  assign m_axis_tx_data_TVALID = out_valid;

endmodule

// File: tb/tb_gradient_tx_packer.sv
// tb_gradient_tx_packer
// Drives directed and random gradient batches into gradient_tx_packer.
// Every emitted line is checked against lines that a queue model builds from each batch.
// Honours GRADIENT_TX_ZERO_PAD_EN: when it is defined, unused lanes must be zero.
module tb_gradient_tx_packer;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } line_t;

  logic         clk;
  logic         rst;
  logic [31:0]  num_gradients;
  logic [31:0]  g_tdata;
  logic         g_tvalid;
  logic         g_tready;
  logic [511:0] tx_tdata;
  logic [63:0]  tx_tkeep;
  logic         tx_tvalid;
  logic         tx_tlast;
  logic         tx_tready;

  int           total;
  int           bad;
  int           accept_count;
  int           ready_mode;
  line_t        exp_q[$];
  logic [31:0]  batch_vals[$];

  gradient_tx_packer dut (
    .clk                   (clk),
    .rst                   (rst),
    .num_gradients         (num_gradients),
    .batch_gradient_TDATA  (g_tdata),
    .batch_gradient_TVALID (g_tvalid),
    .batch_gradient_TREADY (g_tready),
    .m_axis_tx_data_TDATA  (tx_tdata),
    .m_axis_tx_data_TKEEP  (tx_tkeep),
    .m_axis_tx_data_TVALID (tx_tvalid),
    .m_axis_tx_data_TLAST  (tx_tlast),
    .m_axis_tx_data_TREADY (tx_tready)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Downstream ready: 0 = always ready, 1 = stalled, 2 = random
  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = 1'b0;
        default: tx_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check_output(input string tag, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] int_to_float(input int v);
    int e;
    logic [31:0] m;
    e = 0;
    for (int i = 0; i < 31; i++) if (v[i]) e = i;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Reference model: split a batch into groups of 16 and build one expected line per group
  task automatic push_lines(input int n);
    int nn;
    int lane;
    line_t ln;
    nn = (n == 0) ? 1 : n;
    lane = 0;
    ln.data = '0;
    ln.keep = '0;
    ln.last = 1'b0;
    for (int i = 0; i < nn; i++) begin
      ln.data[32 * lane +: 32] = batch_vals[i];
      ln.keep[4 * lane +: 4] = 4'hF;
      lane++;
      if (lane == 16 || i == nn - 1) begin
        ln.last = (i == nn - 1);
        exp_q.push_back(ln);
        ln.data = '0;
        ln.keep = '0;
        lane = 0;
      end
    end
  endtask

  // Monitor: check each handshaked line against the model and confirm outputs hold while stalled
  initial begin
    logic         hold;
    logic [511:0] held_data;
    logic [63:0]  held_keep;
    logic         held_last;
    logic [511:0] mask;
    line_t        e;
    hold = 1'b0;
    held_data = '0;
    held_keep = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check_output("hold_valid", 512'(tx_tvalid), 512'(1));
          check_output("hold_data", tx_tdata, held_data);
          check_output("hold_keep_last", {tx_tkeep, tx_tlast}, {held_keep, held_last});
        end
        if (tx_tvalid && tx_tready) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_line", 512'(1), 512'(0));
          end else begin
            e = exp_q.pop_front();
`ifdef GRADIENT_TX_ZERO_PAD_EN
            mask = '1;
`else
            for (int b = 0; b < 64; b++) mask[8 * b +: 8] = {8{e.keep[b]}};
`endif
            check_output("line_data", tx_tdata & mask, e.data);
            check_output("line_keep", 512'(tx_tkeep), 512'(e.keep));
            check_output("line_last", 512'(tx_tlast), 512'(e.last));
          end
        end
        hold = tx_tvalid && !tx_tready;
        held_data = tx_tdata;
        held_keep = tx_tkeep;
        held_last = tx_tlast;
      end
    end
  end

  // Present one gradient and wait, with a cycle bound, for it to be accepted
  task automatic apply_stimulus(input logic [31:0] val);
    bit ok;
    ok = 1'b0;
    g_tdata = val;
    g_tvalid = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (g_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("accept_timeout", 512'(0), 512'(1));
    @(posedge clk);
    #1;
    g_tvalid = 1'b0;
    if (ok) accept_count++;
  endtask

  // Send a whole batch from batch_vals; num_gradients is scrambled after the first accept
  task automatic send_batch(input int n, input int gap_max);
    int nn;
    nn = (n == 0) ? 1 : n;
    push_lines(n);
    num_gradients = 32'(n);
    for (int i = 0; i < nn; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
      apply_stimulus(batch_vals[i]);
      if (i == 0) num_gradients = $urandom;
    end
  endtask

  task automatic fill_counting(input int n);
    batch_vals.delete();
    for (int i = 0; i < n; i++) batch_vals.push_back(int_to_float(i + 1));
  endtask

  task automatic fill_random(input int n);
    batch_vals.delete();
    for (int i = 0; i < n; i++) batch_vals.push_back($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_tvalid"}, 512'(tx_tvalid), 512'(0));
    check_output({tag, "_tlast"}, 512'(tx_tlast), 512'(0));
    check_output({tag, "_tkeep"}, 512'(tx_tkeep), 512'(0));
    check_output({tag, "_tdata"}, tx_tdata, 512'(0));
    check_output({tag, "_gready"}, 512'(g_tready), 512'(0));
  endtask

  // Main sequence
  initial begin
    int base;
    int n;
    total = 0;
    bad = 0;
    accept_count = 0;
    ready_mode = 0;
    rst = 1'b0;
    g_tvalid = 1'b0;
    g_tdata = '0;
    num_gradients = '0;

    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("ready_before_first_edge", 512'(g_tready), 512'(0));
    @(posedge clk);
    #1;
    check_output("ready_after_reset", 512'(g_tready), 512'(1));

    // Full line of 1.0..16.0, back to back
    fill_counting(16);
    send_batch(16, 0);
    check_output("tvalid_one_cycle_after_16", 512'(tx_tvalid), 512'(1));
    repeat (3) @(posedge clk);
    #1;

    // Twenty gradients give two lines
    fill_counting(20);
    send_batch(20, 0);
    repeat (3) @(posedge clk);
    #1;

    // Downstream stall: 32 accepts, then backpressure
    ready_mode = 1;
    @(posedge clk);
    #1;
    base = accept_count;
    fill_counting(48);
    fork
      send_batch(48, 0);
      begin
        repeat (40) @(posedge clk);
        #2;
        check_output("accepts_during_stall", 512'(accept_count - base), 512'(32));
        check_output("gready_low_during_stall", 512'(g_tready), 512'(0));
        ready_mode = 0;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // num_gradients = 0 is treated as one gradient
    fill_random(1);
    send_batch(0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-batch while a line is held in the output register
    ready_mode = 1;
    @(posedge clk);
    #1;
    fill_random(16);
    send_batch(16, 0);
    fill_random(7);
    num_gradients = 32'd16;
    for (int i = 0; i < 7; i++) apply_stimulus(batch_vals[i]);
    check_output("tvalid_before_reset", 512'(tx_tvalid), 512'(1));
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("midreset");
    ready_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("ready_after_midreset", 512'(g_tready), 512'(1));
    fill_counting(16);
    send_batch(16, 0);
    repeat (3) @(posedge clk);
    #1;

    // Random batches with random gaps and random backpressure
    ready_mode = 2;
    for (int b = 0; b < 10; b++) begin
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      fill_random((n == 0) ? 1 : n);
      send_batch(n, int'($urandom_range(0, 2)));
    end

    // Drain, with a cycle bound
    ready_mode = 0;
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check_output("all_lines_seen", 512'(exp_q.size()), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
